hex_fragment_serializer: RTL and testbench

Downstream stage of the hexagonal fill rasterizer. Captures one parallel burst of filled hexes (axial q/r, depth, count) in a single cycle. Clips each hex against the axial grid window and streams the survivors one per cycle over a valid/ready interface, each with a linear framebuffer address, toward the depth-test/framebuffer stage. Back-pressure is absorbed here; the fill stage is never stalled, so bursts arriving while busy are dropped and flagged.

---
 rtl/hex_fragment_serializer.sv | 174 +++++++++++++++++
 tb/tb_hex_fragment_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_fragment_serializer.sv
// Captures one burst of filled hexes, clips it against the grid window and
// streams the surviving entries in index order over a valid/ready interface.
module hex_fragment_serializer #(
  parameter int MAX_IN = 64,
  parameter int GRID_W = 64,
  parameter int GRID_H = 64,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic signed [15:0]       q_in     [MAX_IN],
  input  logic signed [15:0]       r_in     [MAX_IN],
  input  logic        [7:0]        depth_in [MAX_IN],
  input  logic        [7:0]        count_in,
  output logic                     in_ready,
  output logic                     frag_valid,
  input  logic                     frag_ready,
  output logic signed [15:0]       frag_q,
  output logic signed [15:0]       frag_r,
  output logic        [7:0]        frag_depth,
  output logic        [ADDR_W-1:0] frag_addr,
  output logic                     frag_last,
  output logic                     done,
  output logic        [7:0]        clipped_count,
  output logic                     overflow
);

  localparam int IDX_W = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
  localparam logic [MAX_IN-1:0] MASK_ONE = {{(MAX_IN-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t state_q, state_d;

  logic [MAX_IN-1:0] mask_q, mask_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        clipped_q, clipped_d;

  logic signed [15:0] qBank_q     [MAX_IN];
  logic signed [15:0] rBank_q     [MAX_IN];
  logic        [7:0]  depthBank_q [MAX_IN];

  logic [MAX_IN-1:0] captureMask;
  logic [7:0]        captureClipped;
  logic              capture;
  logic [IDX_W-1:0]  curIdx;
  logic              isLast;
  logic signed [15:0] curQ, curR;
  logic        [7:0]  curDepth;

  // Clip the incoming burst: an entry survives only if it lies inside the
  // effective count and inside the grid window (signed compares).
  always_comb begin
    int effCount;
    int survivors;
    effCount    = (int'(count_in) > MAX_IN) ? MAX_IN : int'(count_in);
    survivors   = 0;
    captureMask = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if ((i < effCount) &&
          (int'(q_in[i]) >= 0) && (int'(q_in[i]) < GRID_W) &&
          (int'(r_in[i]) >= 0) && (int'(r_in[i]) < GRID_H)) begin
        captureMask[i] = 1'b1;
        survivors      = survivors + 1;
      end
    end
    captureClipped = 8'(effCount - survivors);
  end

  // Lowest set mask bit selects the current entry, giving input index order.
  always_comb begin
    curIdx = '0;
    for (int i = MAX_IN - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        curIdx = IDX_W'(i);
      end
    end
  end

  assign curQ     = qBank_q[curIdx];
  assign curR     = rBank_q[curIdx];
  assign curDepth = depthBank_q[curIdx];
  assign isLast   = ((mask_q & (mask_q - MASK_ONE)) == '0);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    clipped_d  = clipped_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          capture   = 1'b1;
          mask_d    = captureMask;
          clipped_d = captureClipped;
          if (|captureMask) begin
            state_d = EMIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (valid_in) begin
          overflow_d = 1'b1;
        end
        if (frag_ready) begin
          mask_d = mask_q & (mask_q - MASK_ONE);
          if (isLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      clipped_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      clipped_q  <= clipped_d;
    end
  end

  // The entry bank needs no reset: outputs are forced to zero outside EMIT.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < MAX_IN; i++) begin
        qBank_q[i]     <= q_in[i];
        rBank_q[i]     <= r_in[i];
        depthBank_q[i] <= depth_in[i];
      end
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    frag_valid = (state_q == EMIT);
    frag_q     = '0;
    frag_r     = '0;
    frag_depth = '0;
    frag_addr  = '0;
    frag_last  = 1'b0;
    if (state_q == EMIT) begin
      frag_q     = curQ;
      frag_r     = curR;
      frag_depth = curDepth;
      frag_addr  = ADDR_W'(int'(curR) * GRID_W + int'(curQ));
      frag_last  = isLast;
    end
  end

  assign done          = done_q;
  assign overflow      = overflow_q;
  assign clipped_count = clipped_q;

endmodule

// File: tb/tb_hex_fragment_serializer.sv
// Randomized and directed bench for hex_fragment_serializer, checked against
// a queue-based model of the clip-and-stream behaviour.
module tb_hex_fragment_serializer;

  localparam int MAX_IN = 64;
  localparam int GRID_W = 64;
  localparam int GRID_H = 64;
  localparam int ADDR_W = 12;

  logic                     clk;
  logic                     reset;
  logic                     valid_in;
  logic signed [15:0]       qIn     [MAX_IN];
  logic signed [15:0]       rIn     [MAX_IN];
  logic        [7:0]        depthIn [MAX_IN];
  logic        [7:0]        countIn;
  logic                     in_ready;
  logic                     frag_valid;
  logic                     frag_ready;
  logic signed [15:0]       frag_q;
  logic signed [15:0]       frag_r;
  logic        [7:0]        frag_depth;
  logic        [ADDR_W-1:0] frag_addr;
  logic                     frag_last;
  logic                     done;
  logic        [7:0]        clipped_count;
  logic                     overflow;

  typedef struct {
    int q;
    int r;
    int depth;
    int addr;
  } frag_t;

  frag_t expQ[$];
  int    expClipped;
  int    nCompared   = 0;
  int    nMismatched = 0;

  hex_fragment_serializer #(
    .MAX_IN(MAX_IN),
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .q_in         (qIn),
    .r_in         (rIn),
    .depth_in     (depthIn),
    .count_in     (countIn),
    .in_ready     (in_ready),
    .frag_valid   (frag_valid),
    .frag_ready   (frag_ready),
    .frag_q       (frag_q),
    .frag_r       (frag_r),
    .frag_depth   (frag_depth),
    .frag_addr    (frag_addr),
    .frag_last    (frag_last),
    .done         (done),
    .clipped_count(clipped_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected stream: in-window entries among the first min(count, MAX_IN), in index order.
  task automatic buildModel();
    int eff;
    expQ.delete();
    eff = (int'(countIn) > MAX_IN) ? MAX_IN : int'(countIn);
    for (int i = 0; i < eff; i++) begin
      int q;
      int r;
      q = int'(qIn[i]);
      r = int'(rIn[i]);
      if (q >= 0 && q < GRID_W && r >= 0 && r < GRID_H) begin
        expQ.push_back('{q, r, int'(depthIn[i]), (r * GRID_W + q) % (1 << ADDR_W)});
      end
    end
    expClipped = eff - expQ.size();
  endtask

  // Hexagon of radius rad around (cq,cr); unused slots get in-window garbage.
  task automatic setHexBurst(input int cq, input int cr, input int rad);
    int n;
    n = 0;
    for (int dq = -rad; dq <= rad; dq++) begin
      for (int dr = -rad; dr <= rad; dr++) begin
        if ((dq + dr) >= -rad && (dq + dr) <= rad) begin
          qIn[n]     = 16'(cq + dq);
          rIn[n]     = 16'(cr + dr);
          depthIn[n] = 8'($urandom);
          n++;
        end
      end
    end
    for (int i = n; i < MAX_IN; i++) begin
      qIn[i]     = 16'($urandom_range(0, GRID_W - 1));
      rIn[i]     = 16'($urandom_range(0, GRID_H - 1));
      depthIn[i] = 8'($urandom);
    end
    countIn = 8'(n);
  endtask

  task automatic setRandomBurst();
    for (int i = 0; i < MAX_IN; i++) begin
      qIn[i]     = 16'(int'($urandom_range(0, 80)) - 8);
      rIn[i]     = 16'(int'($urandom_range(0, 80)) - 8);
      depthIn[i] = 8'($urandom);
    end
    countIn = 8'($urandom_range(0, 70));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_fvalid"}, frag_valid, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_q"}, frag_q, 0);
    checkOutput({tag, "_r"}, frag_r, 0);
    checkOutput({tag, "_depth"}, frag_depth, 0);
    checkOutput({tag, "_addr"}, frag_addr, 0);
    checkOutput({tag, "_last"}, frag_last, 0);
    checkOutput({tag, "_clipped"}, clipped_count, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
  endtask

  // Called on a falling edge; returns on the falling edge of the done cycle.
  // readyMode: 0 always ready, 1 pattern 1,0,0, 2 random.
  task automatic applyStimulus(input int readyMode, input int overflowAt, input int abortAfter);
    int pops;
    bit rdy;
    buildModel();
    checkOutput("accept_ready", in_ready, 1);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("clipped", clipped_count, expClipped);
    if (expQ.size() == 0) begin
      checkOutput("empty_done", done, 1);
      checkOutput("empty_fvalid", frag_valid, 0);
      return;
    end
    pops = 0;
    for (int cyc = 0; cyc < 400 && expQ.size() > 0; cyc++) begin
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 0);
        default: rdy = (cyc > 200) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      frag_ready = rdy;
      checkOutput("fvalid", frag_valid, 1);
      checkOutput("busy_ready", in_ready, 0);
      checkOutput("busy_done", done, 0);
      checkOutput("frag_q", frag_q, expQ[0].q);
      checkOutput("frag_r", frag_r, expQ[0].r);
      checkOutput("frag_depth", frag_depth, expQ[0].depth);
      checkOutput("frag_addr", frag_addr, expQ[0].addr);
      checkOutput("frag_last", frag_last, (expQ.size() == 1) ? 1 : 0);
      checkOutput("clipped_hold", clipped_count, expClipped);
      if (cyc == overflowAt) begin
        setRandomBurst();
        valid_in = 1'b1;
      end
      @(negedge clk);
      valid_in = 1'b0;
      if (rdy) begin
        void'(expQ.pop_front());
        pops++;
        if (abortAfter > 0 && pops == abortAfter) begin
          reset = 1'b1;
          #1;
          checkOutput("abort_fvalid_in_reset", frag_valid, 0);
          @(negedge clk);
          reset = 1'b0;
          #1;
          checkResetValues("abort");
          @(negedge clk);
          checkOutput("abort_no_done", done, 0);
          checkOutput("abort_no_frag", frag_valid, 0);
          return;
        end
      end
    end
    checkOutput("drain_done", done, 1);
    checkOutput("drain_in_ready", in_ready, 1);
    checkOutput("drain_fvalid", frag_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    valid_in   = 1'b0;
    frag_ready = 1'b0;
    countIn    = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      qIn[i]     = '0;
      rIn[i]     = '0;
      depthIn[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetValues("reset");

    $display("[TB] full hexagon at (10,10), always ready");
    setHexBurst(10, 10, 2);
    applyStimulus(0, -1, 0);
    checkOutput("c10_clipped", clipped_count, 0);

    $display("[TB] hexagon at (0,0), corner clipping");
    setHexBurst(0, 0, 2);
    applyStimulus(0, -1, 0);
    checkOutput("c0_clipped", clipped_count, 13);

    $display("[TB] back-pressure pattern 1,0,0");
    setHexBurst(10, 10, 2);
    applyStimulus(1, -1, 0);

    $display("[TB] overflow during stream, then burst in done cycle");
    checkOutput("overflow_pre", overflow, 0);
    setHexBurst(10, 10, 2);
    applyStimulus(0, 3, 0);
    checkOutput("overflow_set", overflow, 1);
    setHexBurst(20, 30, 2);
    applyStimulus(2, -1, 0);
    checkOutput("overflow_sticky", overflow, 1);

    $display("[TB] zero count and fully clipped bursts");
    setHexBurst(10, 10, 2);
    countIn = 8'd0;
    applyStimulus(0, -1, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    setHexBurst(-5, -5, 2);
    applyStimulus(0, -1, 0);
    checkOutput("cneg_clipped", clipped_count, 19);
    @(negedge clk);

    $display("[TB] randomized bursts");
    for (int k = 0; k < 20; k++) begin
      setRandomBurst();
      applyStimulus(2, -1, 0);
    end

    $display("[TB] reset in the middle of a stream");
    @(negedge clk);
    setHexBurst(10, 10, 2);
    applyStimulus(0, -1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
